// File: rtl/r1_sevenseg_display.sv
// Seven-segment display stage for the CPU r1 debug byte: sequential double-dabble
// conversion to 3 decimal digits (or direct 2 hex digits), scanned onto a 4-digit common-anode display.
module r1_sevenseg_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] value,
    input  logic       hex_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [7:0]  shift_reg;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [19:0] dd_shifted;
    logic [2:0]  bit_cnt;
    logic [7:0]  last_value;
    logic        last_mode;
    logic        valid;
    logic        disp_hex;
    logic [3:0]  d2, d1, d0;
    logic        start;

    logic [1:0]  sel;
    logic [3:0]  cur_digit;
    logic        slot_on;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0:    seg_code = 7'b1000000;
            4'h1:    seg_code = 7'b1111001;
            4'h2:    seg_code = 7'b0100100;
            4'h3:    seg_code = 7'b0110000;
            4'h4:    seg_code = 7'b0011001;
            4'h5:    seg_code = 7'b0010010;
            4'h6:    seg_code = 7'b0000010;
            4'h7:    seg_code = 7'b1111000;
            4'h8:    seg_code = 7'b0000000;
            4'h9:    seg_code = 7'b0010000;
            4'hA:    seg_code = 7'b0001000;
            4'hB:    seg_code = 7'b0000011;
            4'hC:    seg_code = 7'b1000110;
            4'hD:    seg_code = 7'b0100001;
            4'hE:    seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    assign start = !valid || (value != last_value) || (hex_mode != last_mode);
    assign busy  = (state != IDLE);

    // Double-dabble step: correct each BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign dd_shifted = {bcd_adj, shift_reg} << 1;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = hex_mode ? LOAD : CONV;
            end
            CONV: begin
                if (bit_cnt == 3'd7)
                    state_next = LOAD;
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg  <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            last_value <= '0;
            last_mode  <= 1'b0;
            valid      <= 1'b0;
            disp_hex   <= 1'b0;
            d2         <= '0;
            d1         <= '0;
            d0         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg  <= value;
                        last_value <= value;
                        last_mode  <= hex_mode;
                        bcd        <= '0;
                        bit_cnt    <= '0;
                    end
                end
                CONV: begin
                    bcd       <= dd_shifted[19:8];
                    shift_reg <= dd_shifted[7:0];
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                LOAD: begin
                    // Display mode is latched with the digits so blanking always matches them.
                    if (last_mode) begin
                        d2 <= 4'd0;
                        d1 <= last_value[7:4];
                        d0 <= last_value[3:0];
                    end else begin
                        d2 <= bcd[11:8];
                        d1 <= bcd[7:4];
                        d0 <= bcd[3:0];
                    end
                    disp_hex <= last_mode;
                    valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + 1'b1;
    end

    assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        cur_digit = d0;
        slot_on   = 1'b0;
        case (sel)
            2'd0: begin
                cur_digit = d0;
                slot_on   = valid;
            end
            2'd1: begin
                cur_digit = d1;
                slot_on   = valid && (disp_hex || d2 != 4'd0 || d1 != 4'd0);
            end
            2'd2: begin
                cur_digit = d2;
                slot_on   = valid && !disp_hex && (d2 != 4'd0);
            end
            default: begin
                cur_digit = d0;
                slot_on   = 1'b0;
            end
        endcase
        an_next  = slot_on ? ~(4'b0001 << sel) : 4'b1111;
        seg_next = slot_on ? seg_code(cur_digit) : 7'b1111111;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_r1_sevenseg_display.sv
// Bench for r1_sevenseg_display: directed values, expected display frames queued per
// completed conversion and checked against every scanned output sample.
module tb_r1_sevenseg_display;

    localparam int RB = 4;
    localparam logic [6:0] BL = 7'b1111111;
    // Frame: {shown mask[3:0], seg slot3, seg slot2, seg slot1, seg slot0}
    localparam logic [31:0] BLANK_FRAME = {4'b0000, BL, BL, BL, BL};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] value = 8'd0;
    logic       hex_mode = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_frame = BLANK_FRAME;
    bit          mon_active = 1'b0;
    bit          stop_mon = 1'b0;
    logic        busy_prev = 1'b0;
    int          cyc = 0;

    r1_sevenseg_display #(.REFRESH_BITS(RB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .value    (value),
        .hex_mode (hex_mode),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    // Clock / reset-relative cycle model
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: each sample is checked against the current frame;
    // a busy falling edge marks a new completed result, so the next frame is popped.
    always @(negedge CLK) begin
        int s;
        logic [3:0] ea;
        logic [6:0] es;
        if (RST) begin
            mon_active = 1'b1;
            cur_frame  = BLANK_FRAME;
            busy_prev  = 1'b0;
        end else if (mon_active && !stop_mon) begin
            s = ((cyc - 1) & 15) >> 2;
            if (cyc != 0 && cur_frame[28 + s]) begin
                ea = ~(4'b0001 << s);
                es = cur_frame[s*7 +: 7];
            end else begin
                ea = 4'b1111;
                es = BL;
            end
            n_vec++;
            if (an !== ea || seg !== es) begin
                n_err++;
                $display("FAIL scan cyc=%0d slot=%0d: an=%b seg=%b, expected an=%b seg=%b",
                         cyc, s, an, seg, ea, es);
            end
            if (busy_prev === 1'b1 && busy === 1'b0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_completion at cyc=%0d: queue empty, expected a pending frame", cyc);
                end else begin
                    cur_frame = exp_q.pop_front();
                end
            end
            busy_prev = busy;
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int exp_len, input string name);
        int t = 0;
        int n = 0;
        while (busy !== 1'b1 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
        end
        n_vec++;
        if (n != exp_len) begin
            n_err++;
            $display("FAIL busy_len %s: busy high %0d cycles, expected %0d", name, n, exp_len);
        end
    endtask

    task automatic check_val(input string name, input logic [6:0] act, input logic [6:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, expv);
        end
    endtask

    initial begin
        int lit;

        // 1: reset, value 0 decimal -> only slot 0 shows "0"
        exp_q.push_back({4'b0001, BL, BL, BL, 7'b1000000});
        RST = 1'b1;
        step(2);
        check_val("reset_busy", {6'd0, busy}, 7'd0);
        check_val("reset_an", {3'd0, an}, 7'b0001111);
        check_val("reset_seg", seg, BL);
        RST = 1'b0;
        wait_done(9, "dec0");
        step(20);

        // 2: 255 decimal -> 2,5,5
        exp_q.push_back({4'b0111, BL, 7'b0100100, 7'b0010010, 7'b0010010});
        value = 8'd255;
        wait_done(9, "dec255");
        step(20);

        // 3: hex A7 -> "A7" in slots 1,0
        exp_q.push_back({4'b0011, BL, BL, 7'b0001000, 7'b1111000});
        value = 8'hA7;
        hex_mode = 1'b1;
        wait_done(1, "hexA7");
        step(20);

        // 4: 100 decimal, changed to 42 during the 3rd conversion step
        exp_q.push_back({4'b0111, BL, 7'b1111001, 7'b1000000, 7'b1000000});
        exp_q.push_back({4'b0011, BL, BL, 7'b0011001, 7'b0100100});
        value = 8'd100;
        hex_mode = 1'b0;
        fork
            wait_done(9, "dec100");
            begin
                step(3);
                value = 8'd42;
            end
        join
        wait_done(9, "dec42");
        step(20);

        // 5: reset in the middle of a conversion, then full reconversion of 200
        value = 8'd200;
        step(4);
        check_val("mid_conv_busy", {6'd0, busy}, 7'd1);
        RST = 1'b1;
        step(1);
        check_val("rst_mid_busy", {6'd0, busy}, 7'd0);
        check_val("rst_mid_an", {3'd0, an}, 7'b0001111);
        check_val("rst_mid_seg", seg, BL);
        RST = 1'b0;
        exp_q.push_back({4'b0111, BL, 7'b0100100, 7'b1000000, 7'b1000000});
        wait_done(9, "dec200_after_rst");
        step(20);

        // 6: 7 decimal, free-run: an low only in slot 0, 8 of 32 samples
        exp_q.push_back({4'b0001, BL, BL, BL, 7'b1111000});
        value = 8'd7;
        wait_done(9, "dec7");
        step(2);
        lit = 0;
        repeat (32) begin
            @(negedge CLK);
            if (an == 4'b1110)
                lit++;
        end
        check_val("slot0_count", lit[6:0], 7'd8);

        step(4);
        stop_mon = 1'b1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_frames: %0d left in queue, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
